// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_pkg
//  Description : Constants shared by fir_filt and its coefficient loader:
//                default widths, loader state encoding and error codes.
//  Revision    : 1.0  initial release
// ============================================================================
package dsp_pkg;

  // Default datapath sizing, shared with fir_filt
  localparam int c_coef_width  = 24;
  localparam int c_coef_count  = 16;
  localparam int c_max_shift   = 32;
  localparam int c_ack_timeout = 15;

  // Loader state encoding
  localparam int c_state_w = 4;

  typedef enum logic [c_state_w-1:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_WRITE     = 4'd2,
    ST_ACK       = 4'd3,
    ST_READ      = 4'd4,
    ST_CHECK     = 4'd5,
    ST_SHIFT     = 4'd6,
    ST_SHIFT_ACK = 4'd7,
    ST_FLUSH     = 4'd8,
    ST_ERR       = 4'd9
  } loader_state_e;

  // err_code values
  localparam logic [1:0] c_err_none     = 2'd0;
  localparam logic [1:0] c_err_coef_to  = 2'd1;
  localparam logic [1:0] c_err_readback = 2'd2;
  localparam logic [1:0] c_err_shift_to = 2'd3;

endpackage : dsp_pkg
`default_nettype wire

// File: rtl/fir_coef_loader_ack_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ack_timer
//  Description : Handshake watchdog. Counts enabled cycles after a clear and
//                flags expiry on the TIMEOUT-th enabled cycle.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   system clock
//    rst_n    in   async active-low reset
//    clear    in   restart the count at zero
//    enable   in   count this cycle (saturates once expired)
//    expired  out  high during the TIMEOUT-th enabled cycle since clear
// ============================================================================
module ack_timer #(
  parameter  int TIMEOUT = 15,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // count_q holds the number of enabled cycles already completed, so the
  // cycle in which it reads TIMEOUT-1 is the last one allowed.
  assign expired = (count_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : ack_timer
`default_nettype wire

// File: rtl/fir_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fir_coef_loader
//  Description : Programs a fir_filt instance: pulls COEF_COUNT words from a
//                valid/ready source, writes each to addr 0..COEF_COUNT-1,
//                reads it back for verification, programs the result shift
//                and finally flushes the filter.
//  Revision    : 1.0  initial release
//
//  Ports
//    start / shift_val           host command; shift_val sampled on accepted start
//    src_valid/src_data/src_ready coefficient source, addr 0 first
//    addr, coef, coef_ready      write port to fir_filt (1-cycle strobe)
//    coef_done, coef_r           write ack and registered readback from fir_filt
//    result_shift_ready/_i/_done result-shift programming handshake
//    flush                       1-cycle filter flush at end of sequence
//    busy, done, error           status; error sticky until next start
//    err_code, err_addr          cause and address of the last error
// ============================================================================
module fir_coef_loader
  import dsp_pkg::*;
#(
  parameter  int COEF_WIDTH  = c_coef_width,
  parameter  int COEF_COUNT  = c_coef_count,
  parameter  int MAX_SHIFT   = c_max_shift,
  parameter  int ACK_TIMEOUT = c_ack_timeout,
  localparam int COEF_ID_W   = $clog2(COEF_COUNT),
  localparam int MAX_SHIFT_W = $clog2(MAX_SHIFT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [MAX_SHIFT_W-1:0] shift_val,
  input  logic                   src_valid,
  input  logic [COEF_WIDTH-1:0]  src_data,
  output logic                   src_ready,
  output logic [COEF_ID_W-1:0]   addr,
  output logic [COEF_WIDTH-1:0]  coef,
  output logic                   coef_ready,
  input  logic                   coef_done,
  input  logic [COEF_WIDTH-1:0]  coef_r,
  output logic                   result_shift_ready,
  output logic [MAX_SHIFT_W-1:0] result_shift_i,
  input  logic                   result_shift_done,
  output logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [COEF_ID_W-1:0]   err_addr
);

  localparam logic [COEF_ID_W-1:0] c_last_addr = COEF_ID_W'(COEF_COUNT - 1);

  loader_state_e          state_q,    state_d;
  logic [COEF_ID_W-1:0]   addr_q,     addr_d;
  logic [COEF_WIDTH-1:0]  coef_q,     coef_d;
  logic [MAX_SHIFT_W-1:0] shift_q,    shift_d;
  logic                   error_q,    error_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [COEF_ID_W-1:0]   err_addr_q, err_addr_d;

  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;

  // One watchdog serves both handshakes; it is cleared in the strobe state
  // (WRITE / SHIFT) that immediately precedes each wait state.
  ack_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    coef_d     = coef_q;
    shift_d    = shift_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d    = shift_val;
          error_d    = 1'b0;
          err_code_d = c_err_none;
          err_addr_d = '0;
          addr_d     = '0;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (src_valid) begin
          coef_d  = src_data;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        tmr_clear = 1'b1;
        state_d   = ST_ACK;
      end

      ST_ACK: begin
        tmr_enable = 1'b1;
        // An ack arriving in the expiry cycle still counts as on time.
        if (coef_done) begin
          state_d = ST_READ;
        end else if (tmr_expired) begin
          error_d    = 1'b1;
          err_code_d = c_err_coef_to;
          err_addr_d = addr_q;
          state_d    = ST_ERR;
        end
      end

      ST_READ: begin
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (coef_r != coef_q) begin
          error_d    = 1'b1;
          err_code_d = c_err_readback;
          err_addr_d = addr_q;
          state_d    = ST_ERR;
        end else if (addr_q == c_last_addr) begin
          state_d = ST_SHIFT;
        end else begin
          addr_d  = addr_q + COEF_ID_W'(1);
          state_d = ST_FETCH;
        end
      end

      ST_SHIFT: begin
        tmr_clear = 1'b1;
        state_d   = ST_SHIFT_ACK;
      end

      ST_SHIFT_ACK: begin
        tmr_enable = 1'b1;
        if (result_shift_done) begin
          state_d = ST_FLUSH;
        end else if (tmr_expired) begin
          error_d    = 1'b1;
          err_code_d = c_err_shift_to;
          err_addr_d = addr_q;
          state_d    = ST_ERR;
        end
      end

      ST_FLUSH: begin
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      coef_q     <= '0;
      shift_q    <= '0;
      error_q    <= 1'b0;
      err_code_q <= c_err_none;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      coef_q     <= coef_d;
      shift_q    <= shift_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: strobes are pure state decodes, so each one lasts exactly one
  // state and they can never overlap or repeat back to back.
  // --------------------------------------------------------------------------
  assign src_ready          = (state_q == ST_FETCH);
  assign coef_ready         = (state_q == ST_WRITE);
  assign result_shift_ready = (state_q == ST_SHIFT);
  assign flush              = (state_q == ST_FLUSH);
  assign done               = (state_q == ST_FLUSH);
  assign busy               = (state_q != ST_IDLE);
  assign addr               = addr_q;
  assign coef               = coef_q;
  assign result_shift_i     = shift_q;
  assign error              = error_q;
  assign err_code           = err_code_q;
  assign err_addr           = err_addr_q;

endmodule : fir_coef_loader
`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_coef_loader
//  Description : Self-checking bench for fir_coef_loader with a behavioural
//                fir_filt peer and a coefficient source. Accepted source
//                words go into a scoreboard and are matched against each
//                write strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_coef_loader;

  localparam int CW = 24;
  localparam int CN = 16;
  localparam int AW = 4;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [SW-1:0] shift_val;
  logic          src_valid;
  logic [CW-1:0] src_data;
  logic          src_ready;
  logic [AW-1:0] addr;
  logic [CW-1:0] coef;
  logic          coef_ready;
  logic          coef_done = 1'b0;
  logic [CW-1:0] coef_r = '0;
  logic          result_shift_ready;
  logic [SW-1:0] result_shift_i;
  logic          result_shift_done = 1'b0;
  logic          flush;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW-1:0] err_addr;

  always #5 clk = ~clk;

  fir_coef_loader #(
    .COEF_WIDTH  (CW),
    .COEF_COUNT  (CN),
    .MAX_SHIFT   (32),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .shift_val          (shift_val),
    .src_valid          (src_valid),
    .src_data           (src_data),
    .src_ready          (src_ready),
    .addr               (addr),
    .coef               (coef),
    .coef_ready         (coef_ready),
    .coef_done          (coef_done),
    .coef_r             (coef_r),
    .result_shift_ready (result_shift_ready),
    .result_shift_i     (result_shift_i),
    .result_shift_done  (result_shift_done),
    .flush              (flush),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .err_code           (err_code),
    .err_addr           (err_addr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- coefficient source ----------------
  int          src_idx = 0;
  logic        src_stall;
  logic [CW-1:0] src_base;
  assign src_valid = src_stall ? (cyc % 3 == 0) : 1'b1;
  assign src_data  = src_base + CW'(src_idx);

  always @(posedge clk) begin
    if (start && !busy) src_idx <= 0;
    else if (src_valid && src_ready) src_idx <= src_idx + 1;
  end

  // ---------------- fir_filt peer model ----------------
  logic [CW-1:0] mem [CN];
  logic [SW-1:0] rs_val = '0;
  logic          blk_en;
  logic [AW-1:0] blk_addr;
  logic          cor_en;
  logic [AW-1:0] cor_addr;

  always @(posedge clk) begin
    coef_done         <= coef_ready && !(blk_en && addr == blk_addr);
    result_shift_done <= result_shift_ready;
    if (result_shift_ready) rs_val <= result_shift_i;
    if (start && !busy) begin
      for (int i = 0; i < CN; i++) mem[i] <= '0;
    end else if (coef_ready) begin
      mem[addr] <= coef;
    end
    coef_r <= (cor_en && addr == cor_addr) ? '0 : mem[addr];
  end

  // ---------------- checking ----------------
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [CW-1:0] d;
  } sb_t;

  sb_t sb_q[$];
  int  acc_cnt, write_cnt, done_cnt, flush_cnt, rs_cnt, viol;
  int  done_cyc, wr_cyc, start_cyc;
  bit  prev_accept, prev_strobe;

  // Monitor on the falling edge: scoreboard and protocol rules.
  initial begin
    sb_t e;
    acc_cnt = 0; write_cnt = 0; done_cnt = 0; flush_cnt = 0; rs_cnt = 0; viol = 0;
    done_cyc = 0; wr_cyc = 0; prev_accept = 0; prev_strobe = 0;
    forever begin
      @(negedge clk);
      if (rst_n && start && !busy) begin
        sb_q.delete();
        acc_cnt = 0; write_cnt = 0; done_cnt = 0; flush_cnt = 0; rs_cnt = 0; viol = 0;
      end else begin
        if (coef_ready) begin
          write_cnt++;
          wr_cyc = cyc;
          check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("wr_addr", 32'(addr), 32'(e.a));
            check("wr_coef", 32'(coef), 32'(e.d));
          end
          if (!prev_accept) viol++;
        end
        if ((coef_ready || result_shift_ready || flush) && prev_strobe) viol++;
        if (int'(coef_ready) + int'(result_shift_ready) + int'(flush) > 1) viol++;
        if (src_valid && src_ready) begin
          sb_q.push_back('{a: AW'(acc_cnt), d: src_data});
          acc_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (flush) flush_cnt++;
        if (result_shift_ready) rs_cnt++;
      end
      prev_accept = src_valid && src_ready;
      prev_strobe = coef_ready || result_shift_ready || flush;
    end
  end

  task automatic pulse_start(input logic [SW-1:0] sv);
    @(posedge clk); #1;
    start     = 1'b1;
    shift_val = sv;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int lim, output bit got);
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(posedge clk); #1;
      if (done || error) got = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic verify_mem(input logic [CW-1:0] base);
    for (int i = 0; i < CN; i++)
      check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(base + CW'(i)));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit got;
    rst_n = 1'b0; start = 1'b0; shift_val = '0;
    src_stall = 1'b0; src_base = CW'(1);
    blk_en = 1'b0; blk_addr = '0; cor_en = 1'b0; cor_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 32'({busy, src_ready, coef_ready, result_shift_ready, flush, done, error, err_code}), 32'd0);
    check("rst_addr", 32'({err_addr, addr, result_shift_i}), 32'd0);
    check("rst_coef", 32'(coef), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    // 1: ramp 1..16, free-running source. Start cycle counts as the first of
    //    84: 16 x 5 coefficient cycles, then SHIFT, SHIFT_ACK, FLUSH.
    pulse_start(SW'(8));
    wait_end(200, got);
    check("t1_end_seen", 32'(got), 32'd1);
    check("t1_done_lat", 32'(done_cyc - start_cyc), 32'd83);
    verify_mem(CW'(1));
    check("t1_shift", 32'(rs_val), 32'd8);
    check("t1_writes", 32'(write_cnt), 32'd16);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_flush_cnt", 32'(flush_cnt), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_viol", 32'(viol), 32'd0);

    // 2: source valid only every third cycle
    src_stall = 1'b1;
    pulse_start(SW'(8));
    wait_end(600, got);
    src_stall = 1'b0;
    check("t2_end_seen", 32'(got), 32'd1);
    verify_mem(CW'(1));
    check("t2_shift", 32'(rs_val), 32'd8);
    check("t2_writes", 32'(write_cnt), 32'd16);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_flush_cnt", 32'(flush_cnt), 32'd1);
    check("t2_viol", 32'(viol), 32'd0);

    // 3: readback corrupted at addr 5
    cor_en = 1'b1; cor_addr = AW'(5);
    pulse_start(SW'(8));
    wait_end(200, got);
    cor_en = 1'b0;
    check("t3_end_seen", 32'(got), 32'd1);
    check("t3_error", 32'(error), 32'd1);
    check("t3_err_code", 32'(err_code), 32'd2);
    check("t3_err_addr", 32'(err_addr), 32'd5);
    check("t3_done_cnt", 32'(done_cnt), 32'd0);
    check("t3_flush_cnt", 32'(flush_cnt), 32'd0);
    check("t3_rs_cnt", 32'(rs_cnt), 32'd0);
    check("t3_writes", 32'(write_cnt), 32'd6);
    check("t3_busy", 32'(busy), 32'd0);

    // 4: write ack withheld at addr 0; 15 ACK cycles follow the strobe
    blk_en = 1'b1; blk_addr = AW'(0);
    pulse_start(SW'(8));
    wait_end(100, got);
    check("t4_end_seen", 32'(got), 32'd1);
    check("t4_error", 32'(error), 32'd1);
    check("t4_err_code", 32'(err_code), 32'd1);
    check("t4_err_addr", 32'(err_addr), 32'd0);
    check("t4_writes", 32'(write_cnt), 32'd1);
    check("t4_done_cnt", 32'(done_cnt), 32'd0);
    // error must be up 16 cycles after the strobe, not before
    wait_end(0, got);
    blk_en = 1'b0;

    // 4b: measure timeout latency explicitly
    blk_en = 1'b1;
    pulse_start(SW'(8));
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (error) begin
        got = 1'b1;
        check("t4_to_lat", 32'(cyc - wr_cyc), 32'd16);
      end
    end
    check("t4b_end_seen", 32'(got), 32'd1);
    blk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 5: second start while busy at addr 3 must be ignored
    pulse_start(SW'(21));
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (busy && addr == AW'(3)) got = 1'b1;
    end
    check("t5_addr3_seen", 32'(got), 32'd1);
    start = 1'b1; shift_val = SW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(200, got);
    check("t5_end_seen", 32'(got), 32'd1);
    check("t5_done_lat", 32'(done_cyc - start_cyc), 32'd83);
    check("t5_shift", 32'(rs_val), 32'd21);
    check("t5_writes", 32'(write_cnt), 32'd16);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_error", 32'(error), 32'd0);
    check("t5_viol", 32'(viol), 32'd0);

    // 6: reset asserted during ACK of addr 7, then a full reload
    blk_en = 1'b1; blk_addr = AW'(7);
    pulse_start(SW'(12));
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (coef_ready && addr == AW'(7)) got = 1'b1;
    end
    check("t6_addr7_seen", 32'(got), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", 32'({busy, src_ready, coef_ready, result_shift_ready, flush, done, error, err_code}), 32'd0);
    check("t6_rst_addr", 32'({err_addr, addr, result_shift_i}), 32'd0);
    check("t6_rst_coef", 32'(coef), 32'd0);
    check("t6_done_cnt", 32'(done_cnt), 32'd0);
    blk_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    src_base = CW'(24'h800000);
    pulse_start(SW'(5));
    wait_end(200, got);
    check("t6_end_seen", 32'(got), 32'd1);
    check("t6_done_lat", 32'(done_cyc - start_cyc), 32'd83);
    verify_mem(CW'(24'h800000));
    check("t6_shift", 32'(rs_val), 32'd5);
    check("t6_writes", 32'(write_cnt), 32'd16);
    check("t6_done_cnt", 32'(done_cnt), 32'd1);
    check("t6_error", 32'(error), 32'd0);
    check("t6_viol", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_fir_coef_loader
`default_nettype wire
